// File: rtl/mem_line_controller.sv
// Line-read / word-write controller between the arbiter memory port and a narrow synchronous RAM.
// A line read issues BEATS back-to-back word reads and presents the assembled line with one read_valid pulse.
module mem_line_controller #(
  parameter int ADDR_SIZE       = 16,
  parameter int WRITE_DATA_SIZE = 32,
  parameter int READ_DATA_SIZE  = 512,
  parameter int RAM_DATA_SIZE   = 32,
  parameter int RAM_LATENCY     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       read_en,
  input  logic [ADDR_SIZE-1:0]       read_addr,
  output logic [READ_DATA_SIZE-1:0]  read_data,
  output logic                       read_valid,
  input  logic                       write_en,
  input  logic [ADDR_SIZE-1:0]       write_addr,
  input  logic [WRITE_DATA_SIZE-1:0] write_data,
  output logic                       write_done,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_SIZE-1:0]       ram_addr,
  output logic [RAM_DATA_SIZE-1:0]   ram_wdata,
  input  logic [RAM_DATA_SIZE-1:0]   ram_rdata
);
  localparam int BEATS = READ_DATA_SIZE / RAM_DATA_SIZE;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, READ_ISSUE, READ_DRAIN, READ_DONE, WRITE, WRITE_DONE
  } state_t;

  typedef struct packed {
    logic          vld;
    logic [BW-1:0] beat;
  } tag_t;

  state_t state, state_nxt;
  tag_t [RAM_LATENCY-1:0] tag_pipe;
  tag_t cap_tag;
  logic cap_last;
  logic [BW-1:0] issue_beat, issue_beat_d;
  logic [READ_DATA_SIZE-1:0] line_buf, line_nxt;
  logic ram_en_d, ram_we_d, read_valid_d, write_done_d;
  logic [ADDR_SIZE-1:0] ram_addr_d;
  logic [RAM_DATA_SIZE-1:0] ram_wdata_d;

  // The tag leaving the last stage lines up with the word the RAM is presenting this cycle.
  assign cap_tag  = tag_pipe[RAM_LATENCY-1];
  assign cap_last = cap_tag.vld && (cap_tag.beat == LAST_BEAT);

  always_comb begin
    line_nxt = line_buf;
    if (cap_tag.vld)
      line_nxt[int'(cap_tag.beat)*RAM_DATA_SIZE +: RAM_DATA_SIZE] = ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (read_en) state_nxt = READ_ISSUE;
                  else if (write_en) state_nxt = WRITE;
      READ_ISSUE: if (issue_beat == LAST_BEAT) state_nxt = READ_DRAIN;
      READ_DRAIN: if (cap_last) state_nxt = READ_DONE;
      READ_DONE:  state_nxt = IDLE;
      WRITE:      state_nxt = WRITE_DONE;
      WRITE_DONE: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; the strobe for a cycle is decided at the edge before it.
  always_comb begin
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata;
    issue_beat_d = issue_beat;
    read_valid_d = 1'b0;
    write_done_d = 1'b0;
    case (state)
      IDLE: begin
        if (read_en) begin
          ram_en_d     = 1'b1;
          ram_addr_d   = read_addr;
          issue_beat_d = '0;
        end else if (write_en) begin
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = write_addr;
          ram_wdata_d = write_data;
        end
      end
      READ_ISSUE: begin
        if (issue_beat != LAST_BEAT) begin
          ram_en_d     = 1'b1;
          ram_addr_d   = ram_addr + 1'b1;
          issue_beat_d = issue_beat + 1'b1;
        end
      end
      READ_DRAIN: read_valid_d = cap_last;
      WRITE:      write_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      issue_beat <= '0;
      read_valid <= 1'b0;
      write_done <= 1'b0;
      tag_pipe   <= '0;
      line_buf   <= '0;
      read_data  <= '0;
    end else begin
      ram_en     <= ram_en_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      issue_beat <= issue_beat_d;
      read_valid <= read_valid_d;
      write_done <= write_done_d;
      tag_pipe[0].vld  <= (state == READ_ISSUE);
      tag_pipe[0].beat <= issue_beat;
      for (int k = 1; k < RAM_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      if (cap_tag.vld) line_buf <= line_nxt;
      // read_data only moves when the full line is known, so no partial line is ever visible.
      if (state == READ_DRAIN && cap_last) read_data <= line_nxt;
    end
  end
endmodule

// File: tb/tb_mem_line_controller.sv
// Directed bench: default-latency controller with a writable RAM model, plus a
// RAM_LATENCY=3 instance with a read-only pattern RAM for the latency check.
module tb_mem_line_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default-latency instance
  logic         read_en, write_en;
  logic [15:0]  read_addr, write_addr;
  logic [31:0]  write_data;
  logic [511:0] read_data;
  logic         read_valid, write_done, ram_en, ram_we;
  logic [15:0]  ram_addr;
  logic [31:0]  ram_wdata, ram_rdata;

  // latency-3 instance
  logic         read_en3;
  logic [15:0]  read_addr3;
  logic [511:0] read_data3;
  logic         read_valid3, write_done3, ram_en3, ram_we3;
  logic [15:0]  ram_addr3;
  logic [31:0]  ram_wdata3, ram_rdata3;

  mem_line_controller dut (
    .clk(clk), .rst(rst),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_done(write_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_line_controller #(.RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .read_en(read_en3), .read_addr(read_addr3), .read_data(read_data3), .read_valid(read_valid3),
    .write_en(1'b0), .write_addr(16'h0000), .write_data(32'h0000_0000), .write_done(write_done3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {16'h0000, a} ^ 32'hA5A5_0000;
  endfunction

  // RAM models
  logic [31:0] mem [0:65535];
  initial for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  logic [31:0] rpipe3 [0:2];
  always @(posedge clk) begin
    rpipe3[0] <= ram_en3 ? pat(ram_addr3) : 32'h0;
    rpipe3[1] <= rpipe3[0];
    rpipe3[2] <= rpipe3[1];
  end
  assign ram_rdata3 = rpipe3[2];

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    read_en = 0; write_en = 0; read_addr = 0; write_addr = 0; write_data = 0;
    read_en3 = 0; read_addr3 = 0;
    next_cycle(); next_cycle();
    checks++;
    if ({read_valid, write_done, ram_en, ram_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {read_valid, write_done, ram_en, ram_we});
    end
    checks++;
    if (ram_addr !== 16'h0 || ram_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_ram_bus: got addr %h wdata %h expected 0", ram_addr, ram_wdata);
    end
    checks++;
    if (read_data !== 512'h0 || read_data3 !== 512'h0) begin
      errors++; $display("FAIL reset_read_data: got nonzero line expected 0");
    end
    checks++;
    if ({read_valid3, write_done3, ram_en3, ram_we3} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes_lat3: got %b expected 0000", {read_valid3, write_done3, ram_en3, ram_we3});
    end
    rst = 1'b0;
    next_cycle();
  endtask

  // Full read timing and contents, including wrap-around and hold after the pulse.
  task automatic test_line_read(input logic [15:0] base, input logic [511:0] prev_line);
    logic [15:0] ea;
    logic [31:0] word;
    logic [511:0] exp_line;
    for (int w = 0; w < 16; w++) exp_line[w*32 +: 32] = pat(16'(base + 16'(w)));
    read_addr = base; read_en = 1'b1;
    next_cycle();
    read_en = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      checks++;
      if (ram_en !== (c <= 16) || ram_we !== 1'b0) begin
        errors++; $display("FAIL read_ram_en c%0d: got en %b we %b expected en %b we 0", c, ram_en, ram_we, c <= 16);
      end
      if (c <= 16) begin
        ea = base + 16'(c - 1);
        checks++;
        if (ram_addr !== ea) begin
          errors++; $display("FAIL read_ram_addr c%0d: got %h expected %h", c, ram_addr, ea);
        end
      end
      checks++;
      if (read_valid !== (c == 18) || write_done !== 1'b0) begin
        errors++; $display("FAIL read_valid c%0d: got %b/%b expected %b/0", c, read_valid, write_done, c == 18);
      end
      if (c == 17) begin
        checks++;
        if (read_data !== prev_line) begin
          errors++; $display("FAIL read_data_early c17: line changed before read_valid");
        end
      end
      if (c == 18 || c == 21) begin
        for (int w = 0; w < 16; w++) begin
          word = read_data[w*32 +: 32];
          checks++;
          if (word !== exp_line[w*32 +: 32]) begin
            errors++; $display("FAIL read_word c%0d w%0d: got %h expected %h", c, w, word, exp_line[w*32 +: 32]);
          end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_then_read();
    logic [31:0] word;
    write_addr = 16'h03AF; write_data = 32'h0000_6AFF; write_en = 1'b1;
    next_cycle();
    write_en = 1'b0;
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'h03AF || ram_wdata !== 32'h0000_6AFF) begin
      errors++; $display("FAIL write_issue: got en %b we %b addr %h data %h expected 1 1 03af 00006aff", ram_en, ram_we, ram_addr, ram_wdata);
    end
    checks++;
    if (write_done !== 1'b0) begin
      errors++; $display("FAIL write_done_c1: got %b expected 0", write_done);
    end
    next_cycle();
    checks++;
    if (write_done !== 1'b1 || ram_en !== 1'b0 || read_valid !== 1'b0) begin
      errors++; $display("FAIL write_done_c2: got done %b en %b rv %b expected 1 0 0", write_done, ram_en, read_valid);
    end
    next_cycle();
    checks++;
    if (write_done !== 1'b0) begin
      errors++; $display("FAIL write_done_c3: got %b expected 0", write_done);
    end
    read_addr = 16'h03A0; read_en = 1'b1;
    next_cycle();
    read_en = 1'b0;
    for (int c = 1; c < 18; c++) next_cycle();
    checks++;
    if (read_valid !== 1'b1) begin
      errors++; $display("FAIL write_read_valid: got %b expected 1", read_valid);
    end
    word = read_data[15*32 +: 32];
    checks++;
    if (word !== 32'h0000_6AFF) begin
      errors++; $display("FAIL write_read_word15: got %h expected 00006aff", word);
    end
    word = read_data[31:0];
    checks++;
    if (word !== pat(16'h03A0)) begin
      errors++; $display("FAIL write_read_word0: got %h expected %h", word, pat(16'h03A0));
    end
    next_cycle();
  endtask

  // Read and write requested together: read first, write held by the arbiter until taken.
  task automatic test_read_write_conflict();
    logic [31:0] word;
    read_addr = 16'h1000; read_en = 1'b1;
    write_addr = 16'h2000; write_data = 32'hDEAD_BEEF; write_en = 1'b1;
    next_cycle();
    read_en = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      checks++;
      if (read_valid !== (c == 18)) begin
        errors++; $display("FAIL conflict_read_valid c%0d: got %b expected %b", c, read_valid, c == 18);
      end
      checks++;
      if (write_done !== (c == 21)) begin
        errors++; $display("FAIL conflict_write_done c%0d: got %b expected %b", c, write_done, c == 21);
      end
      checks++;
      if (ram_we !== (c == 20)) begin
        errors++; $display("FAIL conflict_ram_we c%0d: got %b expected %b", c, ram_we, c == 20);
      end
      if (c == 18) begin
        word = read_data[31:0];
        checks++;
        if (word !== pat(16'h1000)) begin
          errors++; $display("FAIL conflict_word0: got %h expected %h", word, pat(16'h1000));
        end
      end
      if (c == 20) begin
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 16'h2000 || ram_wdata !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL conflict_write_issue: got en %b addr %h data %h expected 1 2000 deadbeef", ram_en, ram_addr, ram_wdata);
        end
        write_en = 1'b0;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] word;
    read_addr = 16'h4000; read_en = 1'b1;
    next_cycle();
    read_en = 1'b0;
    for (int c = 1; c < 7; c++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    checks++;
    if ({read_valid, write_done, ram_en, ram_we} !== 4'b0000 || ram_addr !== 16'h0 || ram_wdata !== 32'h0) begin
      errors++; $display("FAIL midreset_outputs: got %b addr %h expected 0000 addr 0000", {read_valid, write_done, ram_en, ram_we}, ram_addr);
    end
    checks++;
    if (read_data !== 512'h0) begin
      errors++; $display("FAIL midreset_read_data: got nonzero line expected 0");
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (read_valid !== 1'b0 || ram_en !== 1'b0) begin
        errors++; $display("FAIL midreset_quiet %0d: got rv %b en %b expected 0 0", c, read_valid, ram_en);
      end
      next_cycle();
    end
    read_addr = 16'h0100; read_en = 1'b1;
    next_cycle();
    read_en = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      checks++;
      if (read_valid !== (c == 18)) begin
        errors++; $display("FAIL postreset_valid c%0d: got %b expected %b", c, read_valid, c == 18);
      end
      if (c == 18) begin
        word = read_data[3*32 +: 32];
        checks++;
        if (word !== pat(16'h0103)) begin
          errors++; $display("FAIL postreset_word3: got %h expected %h", word, pat(16'h0103));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_latency3();
    logic [31:0] word;
    read_addr3 = 16'h5550; read_en3 = 1'b1;
    next_cycle();
    read_en3 = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      checks++;
      if (read_valid3 !== (c == 20)) begin
        errors++; $display("FAIL lat3_valid c%0d: got %b expected %b", c, read_valid3, c == 20);
      end
      checks++;
      if (ram_en3 !== (c <= 16)) begin
        errors++; $display("FAIL lat3_ram_en c%0d: got %b expected %b", c, ram_en3, c <= 16);
      end
      if (c == 19) begin
        checks++;
        if (read_data3 !== 512'h0) begin
          errors++; $display("FAIL lat3_early_line c19: line changed before read_valid");
        end
      end
      if (c == 20) begin
        for (int w = 0; w < 16; w++) begin
          word = read_data3[w*32 +: 32];
          checks++;
          if (word !== pat(16'h5550 + 16'(w))) begin
            errors++; $display("FAIL lat3_word w%0d: got %h expected %h", w, word, pat(16'h5550 + 16'(w)));
          end
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_line_read(16'h7A34, 512'h0);
    test_line_read(16'hFFF8, {
      32'h0000_7A43 ^ 32'hA5A5_0000, 32'h0000_7A42 ^ 32'hA5A5_0000, 32'h0000_7A41 ^ 32'hA5A5_0000, 32'h0000_7A40 ^ 32'hA5A5_0000,
      32'h0000_7A3F ^ 32'hA5A5_0000, 32'h0000_7A3E ^ 32'hA5A5_0000, 32'h0000_7A3D ^ 32'hA5A5_0000, 32'h0000_7A3C ^ 32'hA5A5_0000,
      32'h0000_7A3B ^ 32'hA5A5_0000, 32'h0000_7A3A ^ 32'hA5A5_0000, 32'h0000_7A39 ^ 32'hA5A5_0000, 32'h0000_7A38 ^ 32'hA5A5_0000,
      32'h0000_7A37 ^ 32'hA5A5_0000, 32'h0000_7A36 ^ 32'hA5A5_0000, 32'h0000_7A35 ^ 32'hA5A5_0000, 32'h0000_7A34 ^ 32'hA5A5_0000});
    test_write_then_read();
    test_read_write_conflict();
    test_reset_mid_read();
    test_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
